// File: rtl/adder_chunked.sv
// Multi-cycle add/subtract: adds CHUNK bits per cycle from LSB to MSB and presents the
// result through a valid/ready handshake, with optional signed saturation.
module adder_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [KW-1:0]     k;
    logic              cy;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [WIDTH-1:0]  out_q;
    logic              carry_q, ovf_q;

    logic [CHUNK-1:0]  ca, cb;
    logic [CHUNK:0]    csum;
    logic [WIDTH-1:0]  sum_nx;
    logic              last;
    logic              ovf_nx;

    // Clamp toward the sign of operand A; on overflow that is the sign of the true result.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                  input logic ov,
                                                  input logic a_msb);
        if (SAT != 0 && ov)
            return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

    always_comb begin
        ca     = a_q[int'(k)*CHUNK +: CHUNK];
        cb     = b_q[int'(k)*CHUNK +: CHUNK];
        csum   = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cy};
        sum_nx = sum_q;
        sum_nx[int'(k)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        last   = (k == KW'(N-1));
        // b_q is already inverted for subtraction, so same-sign operands with a flipped result sign is overflow
        ovf_nx = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            cy      <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k  <= '0;
                        cy <= sub;
                    end
                end
                BUSY: begin
                    cy <= csum[CHUNK];
                    if (last) begin
                        k       <= '0;
                        out_q   <= saturate(sum_nx, ovf_nx, a_q[WIDTH-1]);
                        carry_q <= csum[CHUNK];
                        ovf_q   <= ovf_nx;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and partial-sum registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= in1;
            b_q <= sub ? ~in2 : in2;
        end
        if (state == BUSY)
            sum_q <= sum_nx;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_chunked.sv
// Bench for adder_chunked: four builds (wrap, saturating, CHUNK=16, CHUNK=1) share one
// stimulus stream and are checked each cycle against an arithmetic reference model.
module tb_adder_chunked;

    localparam int NN   [4] = '{4, 4, 1, 16};
    localparam int SATV [4] = '{0, 1, 0, 0};

    logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [15:0] in1 = '0, in2 = '0;
    logic [3:0]  rdy, ovld, cyo, ovo;
    logic [15:0] outv [4];

    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    adder_chunked #(.WIDTH(16), .CHUNK(4),  .SAT(0)) d0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[0]), .in1(in1), .in2(in2), .sub(sub), .out_valid(ovld[0]), .out_ready(out_ready),
        .out(outv[0]), .carry(cyo[0]), .ovf(ovo[0]));
    adder_chunked #(.WIDTH(16), .CHUNK(4),  .SAT(1)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[1]), .in1(in1), .in2(in2), .sub(sub), .out_valid(ovld[1]), .out_ready(out_ready),
        .out(outv[1]), .carry(cyo[1]), .ovf(ovo[1]));
    adder_chunked #(.WIDTH(16), .CHUNK(16), .SAT(0)) d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[2]), .in1(in1), .in2(in2), .sub(sub), .out_valid(ovld[2]), .out_ready(out_ready),
        .out(outv[2]), .carry(cyo[2]), .ovf(ovo[2]));
    adder_chunked #(.WIDTH(16), .CHUNK(1),  .SAT(0)) d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[3]), .in1(in1), .in2(in2), .sub(sub), .out_valid(ovld[3]), .out_ready(out_ready),
        .out(outv[3]), .carry(cyo[3]), .ovf(ovo[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic from integer sums rather than bit-level carries.
    function automatic void calc(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 input int sat, output logic [15:0] r, output logic c, output logic o);
        int sa, sb, ex, u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ex = sa - sb;
            u  = int'(a) - int'(b);
            c  = (a >= b);
        end else begin
            ex = sa + sb;
            u  = int'(a) + int'(b);
            c  = (u > 65535);
        end
        r = u[15:0];
        o = (ex > 32767) || (ex < -32768);
        if (sat != 0 && o) r = (ex < 0) ? 16'h8000 : 16'h7FFF;
    endfunction

    // Model state per build: 0 idle, 1 busy (cnt cycles left), 2 done.
    int          ph [4] = '{0, 0, 0, 0};
    int          cnt[4] = '{0, 0, 0, 0};
    logic [15:0] m_out[4] = '{0, 0, 0, 0};
    logic [15:0] p_out[4];
    logic        m_c[4] = '{0, 0, 0, 0};
    logic        m_o[4] = '{0, 0, 0, 0};
    logic        p_c[4], p_o[4];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                ph[i] = 0; cnt[i] = 0; m_out[i] = '0; m_c[i] = 1'b0; m_o[i] = 1'b0;
            end else if (ph[i] == 0) begin
                if (in_valid) begin
                    calc(in1, in2, sub, SATV[i], p_out[i], p_c[i], p_o[i]);
                    cnt[i] = NN[i];
                    ph[i]  = 1;
                end
            end else if (ph[i] == 1) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    ph[i] = 2; m_out[i] = p_out[i]; m_c[i] = p_c[i]; m_o[i] = p_o[i];
                end
            end else if (out_ready) begin
                ph[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d%0d in_ready", i),  32'(rdy[i]),  32'(ph[i] == 0));
            chk($sformatf("d%0d out_valid", i), 32'(ovld[i]), 32'(ph[i] == 2));
            chk($sformatf("d%0d out", i),       32'(outv[i]), 32'(m_out[i]));
            chk($sformatf("d%0d carry", i),     32'(cyo[i]),  32'(m_c[i]));
            chk($sformatf("d%0d ovf", i),       32'(ovo[i]),  32'(m_o[i]));
        end
    end

    int          lat [4];
    logic [15:0] cap_out[4];
    logic        cap_c[4], cap_o[4];

    // One accepted operation with all builds idle; records latency and delivered result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk); #1;
        in1 = a; in2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0; cap_out[i] = 'x; cap_c[i] = 1'bx; cap_o[i] = 1'bx;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom); sub = 1'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (lat[i] == 0 && ovld[i]) begin
                    lat[i] = c; cap_out[i] = outv[i]; cap_c[i] = cyo[i]; cap_o[i] = ovo[i];
                end
            end
        end
    endtask

    logic [15:0] r;
    logic        c, o;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 32'(ovld), 32'h0);
        chk("reset in_ready",  32'(rdy),  32'hF);
        chk("reset out0",      32'(outv[0]), 32'h0);
        chk("reset carry",     32'(cyo), 32'h0);
        chk("reset ovf",       32'(ovo), 32'h0);

        calc(16'd10, 16'd11, 1'b0, 0, r, c, o);
        chk("model 10+11", {15'd0, c, o, r[14:0]}, {15'd0, 1'b0, 1'b0, 15'd21});
        calc(16'h7FFF, 16'h0001, 1'b0, 1, r, c, o);
        chk("model sat 7fff+1", {15'd0, o, r}, {15'd0, 1'b1, 16'h7FFF});
        calc(16'd30, 16'd31, 1'b1, 0, r, c, o);
        chk("model 30-31", {14'd0, c, o, r}, {14'd0, 1'b0, 1'b0, 16'hFFFF});

        @(negedge clk); #1 rst_n = 1'b1;

        run_op(16'd10, 16'd11, 1'b0);
        chk("10+11 latency", 32'(lat[0]), 32'd4);
        chk("10+11 out", 32'(cap_out[0]), 32'd21);
        chk("10+11 carry/ovf", {30'd0, cap_c[0], cap_o[0]}, 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0);
        chk("ffff+1 out", 32'(cap_out[0]), 32'h0);
        chk("ffff+1 carry/ovf", {30'd0, cap_c[0], cap_o[0]}, 32'b10);

        run_op(16'h7FFF, 16'h0001, 1'b0);
        chk("7fff+1 wrap out", 32'(cap_out[0]), 32'h8000);
        chk("7fff+1 wrap ovf", 32'(cap_o[0]), 32'd1);
        chk("7fff+1 sat out", 32'(cap_out[1]), 32'h7FFF);
        chk("7fff+1 sat ovf", 32'(cap_o[1]), 32'd1);

        run_op(16'd30, 16'd31, 1'b1);
        chk("30-31 out", 32'(cap_out[0]), 32'hFFFF);
        chk("30-31 carry/ovf", {30'd0, cap_c[0], cap_o[0]}, 32'd0);

        run_op(16'h8000, 16'h0001, 1'b1);
        chk("8000-1 sat out", 32'(cap_out[1]), 32'h8000);
        chk("8000-1 sat ovf", 32'(cap_o[1]), 32'd1);

        run_op(16'd50, 16'd51, 1'b0);
        chk("chunk16 out", 32'(cap_out[2]), 32'd101);
        chk("chunk16 latency", 32'(lat[2]), 32'd1);
        chk("chunk1 out", 32'(cap_out[3]), 32'd101);
        chk("chunk1 latency", 32'(lat[3]), 32'd16);

        // Stall in DONE with new operands offered the whole time.
        @(negedge clk); #1;
        in1 = 16'd5; in2 = 16'd6; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        repeat (22) @(negedge clk);
        #1;
        chk("stall in_ready", 32'(rdy), 32'h0);
        chk("stall out_valid", 32'(ovld), 32'hF);
        chk("stall out", 32'(outv[0]), 32'd11);
        out_ready = 1'b1;
        @(negedge clk); #1 in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // Abort an operation part-way through.
        #1 in1 = 16'd100; in2 = 16'd200; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(ovld), 32'h0);
        chk("abort out0", 32'(outv[0]), 32'h0);
        chk("abort out2", 32'(outv[2]), 32'h0);
        chk("abort carry/ovf", {28'd0, cyo | ovo}, 32'h0);
        @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        run_op(16'd40, 16'd41, 1'b0);
        chk("post-reset 40+41", 32'(cap_out[0]), 32'd81);
        chk("post-reset latency", 32'(lat[0]), 32'd4);

        repeat (3000) begin
            @(negedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            sub       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: in1 = 16'h7FFF;
                1: in1 = 16'h8000;
                2: in1 = 16'hFFFF;
                default: in1 = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: in2 = 16'h0001;
                1: in2 = 16'h8000;
                2: in2 = 16'hFFFF;
                default: in2 = 16'($urandom);
            endcase
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
